// File: rtl/fma_dot_sequencer.sv
// Drives one accumulating FMA through bias + sum(a[i]*b[i]) and returns the final sum on a ready/valid port.
// Result valid two edges after the last operand handshake; all FMA-facing outputs are registered.
module fma_dot_sequencer #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 cfg_valid_in,
  output logic                 cfg_ready_out,
  input  logic [LEN_W-1:0]     cfg_len_in,
  input  logic [WIDTH-1:0]     cfg_bias_in,
  input  logic                 op_valid_in,
  output logic                 op_ready_out,
  input  logic [WIDTH-1:0]     op_a_in,
  input  logic [WIDTH-1:0]     op_b_in,
  input  logic                 abort_in,
  output logic [3*WIDTH-1:0]   fma_abc_out,
  output logic                 fma_valid_out,
  output logic                 fma_c_valid_out,
  output logic                 fma_output_can_be_valid_out,
  input  logic [WIDTH-1:0]     fma_out_in,
  input  logic                 fma_valid_in,
  output logic                 res_valid_out,
  input  logic                 res_ready_in,
  output logic [WIDTH-1:0]     res_data_out,
  output logic                 busy_out,
  output logic                 err_out
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic               first_q, first_d;
  logic [WIDTH-1:0]   bias_q, bias_d;
  logic [3*WIDTH-1:0] abc_q, abc_d;
  logic               fvld_q, fvld_d;
  logic               cvld_q, cvld_d;
  logic               ocbv_q, ocbv_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               err_q, err_d;
  logic               abort_d1_q, abort_d1_d;
  logic               spurious;

  // A late FMA output is expected in the cycle right after an abort.
  assign spurious = fma_valid_in && (state_q != S_DRAIN) && !abort_d1_q;

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    first_d    = first_q;
    bias_d     = bias_q;
    abc_d      = abc_q;
    fvld_d     = 1'b0;
    cvld_d     = 1'b0;
    ocbv_d     = 1'b0;
    res_d      = res_q;
    err_d      = err_q;
    abort_d1_d = abort_in;

    case (state_q)
      S_IDLE: begin
        if (cfg_valid_in) begin
          bias_d = cfg_bias_in;
          err_d  = 1'b0;
          if (cfg_len_in == '0) begin
            res_d   = cfg_bias_in;
            state_d = S_DONE;
          end else begin
            rem_d   = cfg_len_in;
            first_d = 1'b1;
            state_d = S_ACCUM;
          end
        end
      end
      S_ACCUM: begin
        if (op_valid_in) begin
          abc_d   = {op_a_in, op_b_in, (first_q ? bias_q : {WIDTH{1'b0}})};
          fvld_d  = 1'b1;
          cvld_d  = first_q;
          ocbv_d  = (rem_q == LEN_W'(1));
          first_d = 1'b0;
          rem_d   = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (fma_valid_in) begin
          res_d   = fma_out_in;
          state_d = S_DONE;
        end
      end
      default: begin
        if (res_ready_in) state_d = S_IDLE;
      end
    endcase

    if (spurious) err_d = 1'b1;

    // Abort overrides every handshake taken above.
    if (abort_in) begin
      state_d = S_IDLE;
      rem_d   = '0;
      first_d = 1'b0;
      bias_d  = bias_q;
      fvld_d  = 1'b0;
      cvld_d  = 1'b0;
      ocbv_d  = 1'b0;
      res_d   = res_q;
      err_d   = err_q | spurious;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= S_IDLE;
      rem_q      <= '0;
      first_q    <= 1'b0;
      bias_q     <= '0;
      abc_q      <= '0;
      fvld_q     <= 1'b0;
      cvld_q     <= 1'b0;
      ocbv_q     <= 1'b0;
      res_q      <= '0;
      err_q      <= 1'b0;
      abort_d1_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      first_q    <= first_d;
      bias_q     <= bias_d;
      abc_q      <= abc_d;
      fvld_q     <= fvld_d;
      cvld_q     <= cvld_d;
      ocbv_q     <= ocbv_d;
      res_q      <= res_d;
      err_q      <= err_d;
      abort_d1_q <= abort_d1_d;
    end
  end

  assign cfg_ready_out               = (state_q == S_IDLE);
  assign op_ready_out                = (state_q == S_ACCUM);
  assign res_valid_out               = (state_q == S_DONE);
  assign busy_out                    = (state_q != S_IDLE);
  assign res_data_out                = res_q;
  assign err_out                     = err_q;
  assign fma_abc_out                 = abc_q;
  assign fma_valid_out               = fvld_q;
  assign fma_c_valid_out             = cvld_q;
  assign fma_output_can_be_valid_out = ocbv_q;

endmodule

// File: tb/tb_fma_dot_sequencer.sv
// Directed bench for fma_dot_sequencer with a behavioural accumulating FMA attached.
module tb_fma_dot_sequencer;
  localparam int W  = 16;
  localparam int LW = 8;

  logic           clk_in = 1'b0;
  logic           rst_n_in;
  logic           cfg_valid_in, cfg_ready_out;
  logic [LW-1:0]  cfg_len_in;
  logic [W-1:0]   cfg_bias_in;
  logic           op_valid_in, op_ready_out;
  logic [W-1:0]   op_a_in, op_b_in;
  logic           abort_in;
  logic [3*W-1:0] fma_abc_out;
  logic           fma_valid_out, fma_c_valid_out, fma_output_can_be_valid_out;
  logic [W-1:0]   fma_out_in;
  logic           fma_valid_in;
  logic           res_valid_out, res_ready_in;
  logic [W-1:0]   res_data_out;
  logic           busy_out, err_out;

  fma_dot_sequencer #(.WIDTH(W), .LEN_W(LW)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .cfg_valid_in(cfg_valid_in), .cfg_ready_out(cfg_ready_out),
    .cfg_len_in(cfg_len_in), .cfg_bias_in(cfg_bias_in),
    .op_valid_in(op_valid_in), .op_ready_out(op_ready_out),
    .op_a_in(op_a_in), .op_b_in(op_b_in), .abort_in(abort_in),
    .fma_abc_out(fma_abc_out), .fma_valid_out(fma_valid_out),
    .fma_c_valid_out(fma_c_valid_out),
    .fma_output_can_be_valid_out(fma_output_can_be_valid_out),
    .fma_out_in(fma_out_in), .fma_valid_in(fma_valid_in),
    .res_valid_out(res_valid_out), .res_ready_in(res_ready_in),
    .res_data_out(res_data_out), .busy_out(busy_out), .err_out(err_out)
  );

  always #5 clk_in = ~clk_in;

  // Behavioural FMA: acc = a*b + (c_valid ? c : acc), output valid one edge later.
  logic [W-1:0] fma_acc, m_a, m_b, m_c;
  logic         fma_fv, fv_inj;
  assign m_a = fma_abc_out[3*W-1:2*W];
  assign m_b = fma_abc_out[2*W-1:W];
  assign m_c = fma_abc_out[W-1:0];
  assign fma_out_in   = fma_acc;
  assign fma_valid_in = fma_fv | fv_inj;

  always @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      fma_acc <= '0;
      fma_fv  <= 1'b0;
    end else if (fma_valid_out) begin
      fma_acc <= W'(m_a * m_b) + (fma_c_valid_out ? m_c : fma_acc);
      fma_fv  <= fma_output_can_be_valid_out;
    end else begin
      fma_fv  <= 1'b0;
    end
  end

  typedef struct {
    int                  len;
    logic [W-1:0]        bias;
    logic [3:0][W-1:0]   a;
    logic [3:0][W-1:0]   b;
    logic [W-1:0]        exp;
    int                  gap;
    int                  hold;
  } vec_t;

  vec_t vecs[6];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   pidx, busy_drop;
  logic mon_busy;
  logic [7:0] cmask, omask;

  function automatic vec_t mk(input int len, input logic [W-1:0] bias,
                              input logic [W-1:0] a0, a1, a2, a3,
                              input logic [W-1:0] b0, b1, b2, b3,
                              input logic [W-1:0] exp, input int gap, input int hold);
    vec_t v;
    v.len = len; v.bias = bias;
    v.a[0] = a0; v.a[1] = a1; v.a[2] = a2; v.a[3] = a3;
    v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3;
    v.exp = exp; v.gap = gap; v.hold = hold;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Advance one edge, then sample FMA drive pattern and busy.
  task automatic tick();
    @(posedge clk_in);
    #1;
    if (fma_valid_out) begin
      if (pidx < 8) begin
        cmask[pidx] = fma_c_valid_out;
        omask[pidx] = fma_output_can_be_valid_out;
      end
      pidx++;
    end
    if (mon_busy && !busy_out) busy_drop++;
  endtask

  task automatic run_job(input vec_t v, input string tag);
    int lat, cyc, unstable;
    logic [W-1:0] held;
    pidx = 0; cmask = '0; omask = '0; busy_drop = 0; unstable = 0;
    check({tag, " cfg_ready"}, 32'(cfg_ready_out), 32'd1);
    cfg_valid_in = 1'b1; cfg_len_in = LW'(v.len); cfg_bias_in = v.bias;
    tick();
    cfg_valid_in = 1'b0; mon_busy = 1'b1; cyc = 0;
    for (int i = 0; i < v.len; i++) begin
      op_valid_in = 1'b1; op_a_in = v.a[i]; op_b_in = v.b[i];
      check({tag, " op_ready"}, 32'(op_ready_out), 32'd1);
      tick(); cyc++;
      op_valid_in = 1'b0;
      if (i < v.len - 1) for (int g = 0; g < v.gap; g++) begin tick(); cyc++; end
    end
    lat = 0;
    while (!res_valid_out && lat < 20) begin tick(); lat++; cyc++; end
    check({tag, " latency"}, 32'(lat), (v.len == 0) ? 32'd0 : 32'd2);
    held = res_data_out;
    check({tag, " result"}, 32'(res_data_out), 32'(v.exp));
    for (int h = 0; h < v.hold; h++) begin
      tick(); cyc++;
      if (res_data_out !== held || !res_valid_out) unstable++;
    end
    check({tag, " hold stable"}, 32'(unstable), 32'd0);
    res_ready_in = 1'b1; mon_busy = 1'b0;
    tick(); cyc++;
    res_ready_in = 1'b0;
    check({tag, " back idle"}, {30'd0, cfg_ready_out, busy_out}, 32'd2);
    if (v.gap == 0 && v.hold == 0 && v.len > 0)
      check({tag, " job cycles"}, 32'(cyc), 32'(v.len + 3));
    check({tag, " fma pulses"}, 32'(pidx), 32'(v.len));
    check({tag, " c_valid mask"}, 32'(cmask), (v.len > 0) ? 32'd1 : 32'd0);
    check({tag, " out_en mask"}, 32'(omask), (v.len > 0) ? (32'd1 << (v.len - 1)) : 32'd0);
    check({tag, " busy held"}, 32'(busy_drop), 32'd0);
    check({tag, " err"}, 32'(err_out), 32'd0);
  endtask

  initial begin
    int seen;
    vecs[0] = mk(3, 16'd5, 16'd2, 16'd4, 16'd1, 16'd0, 16'd3, 16'd5, 16'd7, 16'd0, 16'd38, 0, 0);
    vecs[1] = mk(3, 16'd5, 16'd2, 16'd4, 16'd1, 16'd0, 16'd3, 16'd5, 16'd7, 16'd0, 16'd38, 2, 5);
    vecs[2] = mk(0, 16'd9, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd9, 0, 0);
    vecs[3] = mk(1, 16'hFFFF, 16'd1, 16'd0, 16'd0, 16'd0, 16'd1, 16'd0, 16'd0, 16'd0, 16'h0000, 0, 0);
    vecs[4] = mk(4, 16'd100, 16'd10, 16'd20, 16'd30, 16'd40, 16'd1, 16'd2, 16'd3, 16'd4, 16'd400, 1, 1);
    vecs[5] = mk(2, 16'd0, 16'h0100, 16'hFFFF, 16'd0, 16'd0, 16'h0100, 16'd2, 16'd0, 16'd0, 16'hFFFE, 0, 0);

    rst_n_in = 1'b0; cfg_valid_in = 1'b0; cfg_len_in = '0; cfg_bias_in = '0;
    op_valid_in = 1'b0; op_a_in = '0; op_b_in = '0; abort_in = 1'b0;
    res_ready_in = 1'b0; fv_inj = 1'b0; mon_busy = 1'b0; pidx = 0; busy_drop = 0;
    cmask = '0; omask = '0;
    #12;
    check("reset ready/busy/op", {29'd0, cfg_ready_out, busy_out, op_ready_out}, 32'd4);
    check("reset res/err", {30'd0, res_valid_out, err_out}, 32'd0);
    check("reset res_data", 32'(res_data_out), 32'd0);
    check("reset fma ctrl", {29'd0, fma_valid_out, fma_c_valid_out, fma_output_can_be_valid_out}, 32'd0);
    check("reset abc", fma_abc_out[31:0], 32'd0);
    rst_n_in = 1'b1;
    tick();

    for (int k = 0; k < 6; k++) run_job(vecs[k], $sformatf("vec%0d", k));

    // Abort after 2 of 4 pairs, with an op handshake offered in the abort cycle.
    cfg_valid_in = 1'b1; cfg_len_in = 8'd4; cfg_bias_in = 16'd0;
    tick(); cfg_valid_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      op_valid_in = 1'b1; op_a_in = 16'd7; op_b_in = 16'd7; tick();
    end
    abort_in = 1'b1; tick();
    abort_in = 1'b0; op_valid_in = 1'b0;
    check("abort idle", {29'd0, cfg_ready_out, busy_out, op_ready_out}, 32'd4);
    check("abort fma_valid", 32'(fma_valid_out), 32'd0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (res_valid_out) seen++; end
    check("abort no result", 32'(seen), 32'd0);
    check("abort err", 32'(err_out), 32'd0);

    // cfg and abort together in IDLE: job refused.
    cfg_valid_in = 1'b1; cfg_len_in = 8'd1; abort_in = 1'b1;
    tick();
    cfg_valid_in = 1'b0; abort_in = 1'b0;
    check("cfg+abort refused", {30'd0, cfg_ready_out, busy_out}, 32'd2);
    run_job(mk(1, 16'd0, 16'd3, 16'd0, 16'd0, 16'd0, 16'd3, 16'd0, 16'd0, 16'd0, 16'd9, 0, 0), "post_abort");

    // Abort in DRAIN: the late FMA output must not raise err.
    cfg_valid_in = 1'b1; cfg_len_in = 8'd1; cfg_bias_in = 16'd0;
    tick(); cfg_valid_in = 1'b0;
    op_valid_in = 1'b1; op_a_in = 16'd2; op_b_in = 16'd2; tick();
    op_valid_in = 1'b0; abort_in = 1'b1; tick();
    abort_in = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin tick(); if (res_valid_out) seen++; end
    check("drain abort no result", 32'(seen), 32'd0);
    check("drain abort err quiet", 32'(err_out), 32'd0);

    // Stray FMA valid in IDLE is a sticky error, cleared by the next job.
    fv_inj = 1'b1; tick(); fv_inj = 1'b0;
    check("stray valid err", 32'(err_out), 32'd1);
    tick();
    check("err sticky", 32'(err_out), 32'd1);
    run_job(vecs[0], "after_err");

    // Asynchronous reset mid-ACCUM.
    cfg_valid_in = 1'b1; cfg_len_in = 8'd3; cfg_bias_in = 16'd1;
    tick(); cfg_valid_in = 1'b0;
    op_valid_in = 1'b1; op_a_in = 16'd5; op_b_in = 16'd5; tick();
    op_valid_in = 1'b0;
    check("pre-reset fma_valid", 32'(fma_valid_out), 32'd1);
    #2 rst_n_in = 1'b0;
    #1;
    check("async rst state", {29'd0, cfg_ready_out, busy_out, op_ready_out}, 32'd4);
    check("async rst fma", {29'd0, fma_valid_out, fma_c_valid_out, fma_output_can_be_valid_out}, 32'd0);
    check("async rst abc", fma_abc_out[31:0], 32'd0);
    #2 rst_n_in = 1'b1;
    tick();
    run_job(mk(1, 16'd0, 16'd3, 16'd0, 16'd0, 16'd0, 16'd3, 16'd0, 16'd0, 16'd0, 16'd9, 0, 0), "post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
